fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 16 +
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared CPU fetch definitions: state encoding, reset PC, NOP word.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] c_NOP        = 32'h0000_0000;
    localparam logic [31:0] c_INSN_BYTES = 32'd4;

    // Sequential successor; wraps modulo 2^32, low bits pass through.
    function automatic logic [31:0] next_pc(input logic [31:0] addr);
        return addr + c_INSN_BYTES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_if
// Brief  : Instruction-memory request/acknowledge bus.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;

    modport master (output imemReq, output imemAddr, input imemAck, input imemData);
    modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch stage with stall buffering and redirect discard.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP      = c_NOP
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        redirect,
    input  wire logic [31:0] redirectPC,
    fetch_unit_if.master     imem,
    output logic      [31:0] PCOut,
    output logic      [31:0] instructionOut,
    output logic             validOut
);

    fetch_state_t r_state, w_state;
    logic [31:0]  r_pc, w_pc;
    logic [31:0]  r_reqAddr, w_reqAddr;
    logic [31:0]  r_holdBuf, w_holdBuf;
    logic [31:0]  r_holdPC, w_holdPC;
    logic [31:0]  r_pcOut, w_pcOut;
    logic [31:0]  r_instr, w_instr;
    logic         r_valid, w_valid;
    logic [31:0]  w_seqPC;
    logic         w_ack;

    assign w_seqPC = next_pc(r_reqAddr);
    assign w_ack   = imem.imemAck;

    // Control: state, fetch address, request address and hold buffer.
    always_comb begin
        w_state   = r_state;
        w_pc      = r_pc;
        w_reqAddr = r_reqAddr;
        w_holdBuf = r_holdBuf;
        w_holdPC  = r_holdPC;
        case (r_state)
            ST_FETCH: begin
                if (redirect) begin
                    w_pc = redirectPC;
                    if (w_ack) w_reqAddr = redirectPC;
                    else       w_state   = ST_DISCARD;
                end else if (w_ack) begin
                    if (stall) begin
                        w_holdBuf = imem.imemData;
                        w_holdPC  = w_seqPC;
                        w_state   = ST_HOLD;
                    end else begin
                        w_pc      = w_seqPC;
                        w_reqAddr = w_seqPC;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_pc      = redirectPC;
                    w_reqAddr = redirectPC;
                    w_state   = ST_FETCH;
                end else if (!stall) begin
                    w_pc      = r_holdPC;
                    w_reqAddr = r_holdPC;
                    w_state   = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // The stale word is dropped; the newest redirect target is fetched next.
                if (redirect) w_pc = redirectPC;
                if (w_ack) begin
                    w_reqAddr = redirect ? redirectPC : r_pc;
                    w_state   = ST_FETCH;
                end
            end
            default: w_state = ST_FETCH;
        endcase
    end

    // Output slot: redirect forces a bubble, otherwise stall freezes it.
    always_comb begin
        w_pcOut = r_pcOut;
        w_instr = r_instr;
        w_valid = r_valid;
        if (redirect) begin
            w_instr = NOP;
            w_valid = 1'b0;
        end else if (!stall) begin
            if (r_state == ST_FETCH && w_ack) begin
                w_pcOut = w_seqPC;
                w_instr = imem.imemData;
                w_valid = 1'b1;
            end else if (r_state == ST_HOLD) begin
                w_pcOut = r_holdPC;
                w_instr = r_holdBuf;
                w_valid = 1'b1;
            end else begin
                w_instr = NOP;
                w_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_reqAddr <= RESET_PC;
            r_holdBuf <= NOP;
            r_holdPC  <= 32'h0;
            r_pcOut   <= 32'h0;
            r_instr   <= NOP;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_reqAddr <= w_reqAddr;
            r_holdBuf <= w_holdBuf;
            r_holdPC  <= w_holdPC;
            r_pcOut   <= w_pcOut;
            r_instr   <= w_instr;
            r_valid   <= w_valid;
        end
    end

    assign imem.imemReq   = (r_state != ST_HOLD);
    assign imem.imemAddr  = r_reqAddr;
    assign PCOut          = r_pcOut;
    assign instructionOut = r_instr;
    assign validOut       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOPV     = 32'h0000_0000;
    localparam logic [31:0] c_WRAP_PC  = 32'hFFFF_FFFC;
    localparam logic [31:0] c_WRAP_NOP = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = 32'h0;
    logic [31:0] PCOut, instructionOut;
    logic        validOut;

    logic        stall_w = 1'b0;
    logic        redirect_w = 1'b0;
    logic [31:0] redirectPC_w = 32'h0;
    logic [31:0] PCOut_w, instructionOut_w;
    logic        validOut_w;

    int errors = 0;
    int checks = 0;

    fetch_unit_if u_if ();
    fetch_unit_if u_if_w ();

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirectPC(redirectPC), .imem(u_if), .PCOut(PCOut),
        .instructionOut(instructionOut), .validOut(validOut)
    );

    fetch_unit #(.RESET_PC(c_WRAP_PC), .NOP(c_WRAP_NOP)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall(stall_w), .redirect(redirect_w),
        .redirectPC(redirectPC_w), .imem(u_if_w), .PCOut(PCOut_w),
        .instructionOut(instructionOut_w), .validOut(validOut_w)
    );

    always #5 clk = ~clk;

    // Memory contents as a function of address, distinct from NOP at address 0.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Reference model: what the fetch stage owes, in terms of outstanding work.
    logic [31:0] m_req, m_target, m_holdBuf, m_holdPC, m_pcOut, m_instr;
    bit          m_buffered, m_stale, m_valid;

    task automatic model_reset();
        m_req = 32'h0; m_target = 32'h0; m_buffered = 0; m_stale = 0;
        m_holdBuf = c_NOPV; m_holdPC = 32'h0;
        m_pcOut = 32'h0; m_instr = c_NOPV; m_valid = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] rpc, input bit a);
        logic [31:0] d;
        d = mem(m_req);
        if (r) begin
            m_instr = c_NOPV; m_valid = 0;
            m_target = rpc;
            if (m_buffered) begin
                m_buffered = 0; m_req = rpc;
            end else if (m_stale) begin
                if (a) begin m_req = rpc; m_stale = 0; end
            end else if (a) begin
                m_req = rpc;
            end else begin
                m_stale = 1;
            end
        end else if (m_buffered) begin
            if (!s) begin
                m_pcOut = m_holdPC; m_instr = m_holdBuf; m_valid = 1;
                m_req = m_holdPC; m_target = m_holdPC; m_buffered = 0;
            end
        end else if (m_stale) begin
            if (a) begin m_req = m_target; m_stale = 0; end
            if (!s) begin m_instr = c_NOPV; m_valid = 0; end
        end else if (a) begin
            if (s) begin
                m_buffered = 1; m_holdBuf = d; m_holdPC = m_req + 32'd4;
            end else begin
                m_pcOut = m_req + 32'd4; m_instr = d; m_valid = 1;
                m_req = m_req + 32'd4; m_target = m_req;
            end
        end else if (!s) begin
            m_instr = c_NOPV; m_valid = 0;
        end
    endtask

    // Apply one cycle of inputs from a falling edge, return at the next falling edge.
    task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit a);
        stall = s; redirect = r; redirectPC = rpc;
        u_if.imemAck  = a;
        u_if.imemData = a ? mem(u_if.imemAddr) : $urandom();
        if (rst) model_reset();
        else     model_step(s, r, rpc, a);
        @(posedge clk);
        @(negedge clk);
        u_if.imemAck = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h55, 1'b1);
        step(1'b0, 1'b1, 32'h99, 1'b1);
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", validOut); end
        checks++; if (PCOut !== 32'h0) begin errors++; $display("FAIL reset_pcout: got %h want 0", PCOut); end
        checks++; if (instructionOut !== c_NOPV) begin errors++; $display("FAIL reset_instr: got %h want %h", instructionOut, c_NOPV); end
        checks++; if (instructionOut_w !== c_WRAP_NOP) begin errors++; $display("FAIL reset_nop_param: got %h want %h", instructionOut_w, c_WRAP_NOP); end
        rst = 1'b0;
        checks++; if (u_if.imemReq !== 1'b1 || u_if.imemAddr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0", u_if.imemReq, u_if.imemAddr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if (PCOut !== 32'(4 * i) || validOut !== 1'b1 || instructionOut !== mem(32'(4 * (i - 1)))) begin
                errors++; $display("FAIL stream_%0d: got pc=%h v=%b ins=%h want pc=%h v=1 ins=%h",
                                   i, PCOut, validOut, instructionOut, 32'(4 * i), mem(32'(4 * (i - 1))));
            end
        end
        checks++; if (u_if.imemAddr !== 32'hC) begin errors++; $display("FAIL stream_addr: got %h want c", u_if.imemAddr); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (u_if.imemReq !== 1'b0 || PCOut !== 32'h8 || instructionOut !== mem(32'h4) || validOut !== 1'b1) begin
                errors++; $display("FAIL hold_frozen_%0d: got req=%b pc=%h ins=%h v=%b want req=0 pc=8 ins=%h v=1",
                                   i, u_if.imemReq, PCOut, instructionOut, validOut, mem(32'h4));
            end
            if (i < 2) step(1'b1, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (PCOut !== 32'hC || instructionOut !== mem(32'h8) || validOut !== 1'b1) begin
            errors++; $display("FAIL hold_release: got pc=%h ins=%h v=%b want pc=c ins=%h v=1", PCOut, instructionOut, validOut, mem(32'h8));
        end
        checks++; if (u_if.imemReq !== 1'b1 || u_if.imemAddr !== 32'hC) begin
            errors++; $display("FAIL hold_resume_addr: got req=%b addr=%h want req=1 addr=c", u_if.imemReq, u_if.imemAddr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (PCOut !== 32'h10 || instructionOut !== mem(32'hC)) begin
            errors++; $display("FAIL hold_resume_data: got pc=%h ins=%h want pc=10 ins=%h", PCOut, instructionOut, mem(32'hC));
        end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        checks++; if (validOut !== 1'b0 || instructionOut !== c_NOPV || PCOut !== 32'h10) begin
            errors++; $display("FAIL discard_bubble: got v=%b ins=%h pc=%h want v=0 ins=%h pc=10", validOut, instructionOut, PCOut, c_NOPV);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (u_if.imemReq !== 1'b1 || u_if.imemAddr !== 32'h10) begin
            errors++; $display("FAIL discard_addr: got req=%b addr=%h want req=1 addr=10", u_if.imemReq, u_if.imemAddr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (validOut !== 1'b0 || u_if.imemAddr !== 32'h100) begin
            errors++; $display("FAIL discard_drop: got v=%b addr=%h want v=0 addr=100", validOut, u_if.imemAddr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (validOut !== 1'b1 || PCOut !== 32'h104 || instructionOut !== mem(32'h100)) begin
            errors++; $display("FAIL discard_target: got v=%b pc=%h ins=%h want v=1 pc=104 ins=%h", validOut, PCOut, instructionOut, mem(32'h100));
        end
    endtask

    task automatic test_redirect_in_hold();
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        checks++; if (validOut !== 1'b0 || u_if.imemReq !== 1'b1 || u_if.imemAddr !== 32'h200) begin
            errors++; $display("FAIL hold_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=200", validOut, u_if.imemReq, u_if.imemAddr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (PCOut !== 32'h204 || instructionOut !== mem(32'h200) || validOut !== 1'b1) begin
            errors++; $display("FAIL hold_redirect_data: got pc=%h ins=%h v=%b want pc=204 ins=%h v=1", PCOut, instructionOut, validOut, mem(32'h200));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (u_if_w.imemAddr !== c_WRAP_PC) begin errors++; $display("FAIL wrap_reset_addr: got %h want %h", u_if_w.imemAddr, c_WRAP_PC); end
        u_if_w.imemAck  = 1'b1;
        u_if_w.imemData = mem(c_WRAP_PC);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        u_if_w.imemAck  = 1'b0;
        checks++; if (PCOut_w !== 32'h0 || validOut_w !== 1'b1 || instructionOut_w !== mem(c_WRAP_PC) || u_if_w.imemAddr !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got pc=%h v=%b ins=%h addr=%h want pc=0 v=1 ins=%h addr=0",
                               PCOut_w, validOut_w, instructionOut_w, u_if_w.imemAddr, mem(c_WRAP_PC));
        end
    endtask

    task automatic test_reset_in_discard();
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h400, 1'b1);
        checks++; if (validOut !== 1'b0 || PCOut !== 32'h0 || instructionOut !== c_NOPV || u_if.imemAddr !== 32'h0) begin
            errors++; $display("FAIL discard_reset: got v=%b pc=%h ins=%h addr=%h want v=0 pc=0 ins=%h addr=0",
                               validOut, PCOut, instructionOut, u_if.imemAddr, c_NOPV);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (PCOut !== 32'h4 || validOut !== 1'b1 || instructionOut !== mem(32'h0)) begin
            errors++; $display("FAIL discard_reset_fetch: got pc=%h v=%b ins=%h want pc=4 v=1 ins=%h", PCOut, validOut, instructionOut, mem(32'h0));
        end
    endtask

    task automatic test_random();
        bit s, r, a;
        logic [31:0] rpc;
        int stall_pct;
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            checks++; if (u_if.imemReq !== !m_buffered || (!m_buffered && u_if.imemAddr !== m_req)) begin
                errors++; $display("FAIL rand_req cyc %0d: got req=%b addr=%h want req=%b addr=%h", i, u_if.imemReq, u_if.imemAddr, !m_buffered, m_req);
            end
            checks++; if (validOut !== m_valid || PCOut !== m_pcOut || instructionOut !== m_instr) begin
                errors++; $display("FAIL rand_slot cyc %0d: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                                   i, validOut, PCOut, instructionOut, m_valid, m_pcOut, m_instr);
            end
            stall_pct = ((i / 500) % 2 == 0) ? 20 : 60;
            s = ($urandom_range(0, 99) < stall_pct);
            r = ($urandom_range(0, 99) < 10);
            a = !m_buffered && ($urandom_range(0, 99) < 60);
            rpc = ($urandom_range(0, 7) == 0) ? c_WRAP_PC : $urandom();
            step(s, r, rpc, a);
        end
    endtask

    initial begin
        u_if.imemAck    = 1'b0;
        u_if.imemData   = 32'h0;
        u_if_w.imemAck  = 1'b0;
        u_if_w.imemData = 32'h0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold_stall();
        test_redirect_discard();
        test_redirect_in_hold();
        test_wrap();
        test_reset_in_discard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
